sort_stream_host: RTL and testbench
===================================

# sort_stream_host

Host-side sequencer for the bubble-sort datapath. It accepts N unsorted words on a valid/ready input stream and writes them into the sort memory. It then pulses `sort_start` to the sort controller, waits for `sort_done`, and reads the N sorted words back out of memory onto a valid/ready output stream. It is the initiator side of the sorter's start/done handshake and sits between the system bus adapter and the sort top level.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width; matches the sorter data width.
- `N`, 4: words per job; N ≥ 1.
- `ADDR_WIDTH`, max(1, clog2(N)): derived; memory address and counter width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `s_valid`, input, 1: input word valid.
- `s_data`, input, DATA_WIDTH: input word.
- `s_ready`, output, 1: block accepts `s_data` this cycle.
- `m_valid`, output, 1: output word valid.
- `m_data`, output, DATA_WIDTH: sorted word, registered.
- `m_last`, output, 1: qualifies the final word (index N-1).
- `m_ready`, input, 1: downstream accepts.
- `sort_start`, output, 1: one-cycle start pulse to the sort controller.
- `sort_done`, input, 1: sorter completion; level, may stay high.
- `mem_owner`, output, 1: 1 = this block drives the memory port; 0 = the sorter drives it (selects the top-level mux).
- `mem_en`, output, 1: memory enable.
- `mem_we`, output, 1: 1 = write, 0 = read.
- `mem_addr`, output, ADDR_WIDTH: memory address.
- `mem_wdata`, output, DATA_WIDTH: write data.
- `mem_rdata`, input, DATA_WIDTH: read data, valid one cycle after a read request.
- `busy`, output, 1: job in progress, i.e. state is not LOAD or at least one word has been accepted.

## Operation
- FSM states: LOAD, START, WAIT, RD_REQ, RD_CAP, OUT. Reset state is LOAD with `cnt = 0`.
- **LOAD**
  - `s_ready = 1`, `mem_owner = 1`.
  - On `s_valid & s_ready`, in the same cycle: `mem_en = 1`, `mem_we = 1`, `mem_addr = cnt`, `mem_wdata = s_data` (combinational pass-through).
  - `cnt` increments on each accepted beat.
  - When the beat with `cnt == N-1` is accepted: `cnt` clears and the FSM goes to START.
  - Cycles where `s_valid = 0` write nothing.
- **START**: `sort_start = 1` for exactly this one cycle. `mem_owner = 0`. Goes to WAIT.
- **WAIT**: `mem_owner = 0`. When `sort_done = 1` is sampled, go to RD_REQ. `sort_done` is ignored in every other state.
- **RD_REQ**: `mem_owner = 1`, `mem_en = 1`, `mem_we = 0`, `mem_addr = cnt`. Goes to RD_CAP.
- **RD_CAP**: `m_data <= mem_rdata`, `m_last <= (cnt == N-1)`. Goes to OUT.
- **OUT**
  - `m_valid = 1`. `m_data` and `m_last` are held stable until `m_ready`.
  - On handshake: if the word was the last, clear `cnt` and go to LOAD; otherwise increment `cnt` and go to RD_REQ.
- `s_ready = 0` in every state except LOAD; `s_valid` outside LOAD is ignored.
- `mem_en = 0` whenever `mem_owner = 0`.
- Counter rules: `cnt` is ADDR_WIDTH bits, compared against N-1, and never wraps past N-1. For N = 1 the job is a single write and a single read.

## Timing
- Reset values (during `rst` and the cycle it is sampled):
  - `s_ready`, `m_valid`, `m_last`, `sort_start`, `mem_owner`, `mem_en`, `mem_we`, `busy` = 0.
  - `m_data`, `mem_addr`, `mem_wdata` = 0.
- After reset is released, `s_ready = 1` on the first cycle.
- Load phase: one cycle per word at full rate.
- `sort_start` is asserted on the cycle after the N-th accept.
- Read-out phase: 3 cycles per word when `m_ready` is held high; the first `m_valid` appears 3 cycles after `sort_done` is sampled in WAIT.
- No memory read is issued while a word is waiting in OUT.
- Reset mid-operation: the next cycle is LOAD with `cnt = 0` and all outputs at reset values. Any partial job is discarded and memory contents are not cleared.
- Simultaneous events:
  - `sort_done` high on the START cycle is ignored; WAIT samples it on the next cycle.
  - `sort_done` still high after returning to LOAD has no effect.

## Structure
- Shared package `sort_pkg`: the state enum `sort_host_state_t` and the data-width constant shared with the sorter.
- A single module with no sub-modules. The counter and the m_data/m_last output register are inline.

## Test plan
- **Load:** N = 4, feed 0x0004, 0x0003, 0x0002, 0x0001 back-to-back → writes to addr 0..3 on 4 consecutive cycles; `sort_start` is a single pulse on the next cycle; `mem_owner` falls with it.
- **Read-out:** mock sorter raises `sort_done` 10 cycles after start and memory holds 0x0001..0x0004 → reads of addr 0..3; output words 0x0001, 0x0002, 0x0003, 0x0004 at 3-cycle spacing; `m_last` only on 0x0004; FSM back in LOAD with `s_ready = 1`.
- **Output backpressure:** `m_ready` low for 5 cycles on word 1 → `m_valid` held, `m_data = 0x0002` stable, no `mem_en` during the stall.
- **Input gaps:** `s_valid` toggled 1, 0, 1, 0, … → only accepted beats are written, addresses are contiguous 0..3, and `sort_start` follows the 4th accept.
- **Reset mid-operation:** `rst` asserted for 1 cycle during WAIT → all outputs 0; a new 4-word job then completes correctly.
- **Level done:** `sort_done` held high in LOAD and through read-out → no early read and no second `sort_start`.

Source files
------------

// File: rtl/sort_pkg.sv
// Types and constants shared by the sort host sequencer and the sort datapath.
// Declarations only: no latency and no flow control.
package sort_pkg;

    localparam int SORT_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_OUT
    } sort_host_state_t;

    // Address/counter width for a job of n words; a 1-word job still needs one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sort_stream_host_if.sv
// Bundle between the sort host and its neighbours: input/output streams, start/done, memory port.
// Wires only: no latency; valid/ready on both streams.
interface sort_stream_host_if
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 2
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  sort_start;
    logic                  sort_done;
    logic                  mem_owner;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport master (
        input  s_valid, s_data, m_ready, sort_done, mem_rdata,
        output s_ready, m_valid, m_data, m_last, sort_start,
               mem_owner, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output s_valid, s_data, m_ready, sort_done, mem_rdata,
        input  s_ready, m_valid, m_data, m_last, sort_start,
               mem_owner, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/sort_stream_host.sv
// Loads N words into sort memory, kicks the sorter, then streams the sorted words back out.
// Latency: 1 cycle/word in, 3 cycles/word out; output stalls hold m_data/m_last and issue no reads.
module sort_stream_host
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = SORT_DATA_WIDTH,
    parameter int N          = 4,
    localparam int ADDR_WIDTH = addr_width(N)
) (
    input logic               clk,
    input logic               rst,
    sort_stream_host_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    sort_host_state_t      state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  cnt_last;

    assign cnt_last = (cnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.s_valid) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.sort_done) state_d = ST_RD_REQ;
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                m_data_d = bus.mem_rdata;
                m_last_d = cnt_last;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    if (m_last_q) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Outputs are forced to idle while rst is high, not just after it is sampled.
    always_comb begin
        bus.s_ready    = 1'b0;
        bus.m_valid    = 1'b0;
        bus.sort_start = 1'b0;
        bus.mem_owner  = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.m_data     = rst ? '0 : m_data_q;
        bus.m_last     = rst ? 1'b0 : m_last_q;
        bus.busy       = !rst && ((state_q != ST_LOAD) || (cnt_q != '0));
        if (!rst) begin
            case (state_q)
                ST_LOAD: begin
                    bus.s_ready   = 1'b1;
                    bus.mem_owner = 1'b1;
                    if (bus.s_valid) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = 1'b1;
                        bus.mem_addr  = cnt_q;
                        bus.mem_wdata = bus.s_data;
                    end
                end
                ST_START: bus.sort_start = 1'b1;
                ST_RD_REQ: begin
                    bus.mem_owner = 1'b1;
                    bus.mem_en    = 1'b1;
                    bus.mem_addr  = cnt_q;
                end
                ST_RD_CAP: bus.mem_owner = 1'b1;
                ST_OUT: begin
                    bus.mem_owner = 1'b1;
                    bus.m_valid   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_stream_host.sv
// Directed bench: behavioural sort memory, mock sorter, per-cycle event logs checked against hand-computed values.
module tb_sort_stream_host;
    import sort_pkg::*;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int AW = 2;

    typedef logic [N-1:0][DW-1:0] mem_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_stream_host_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sort_stream_host #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model plus mock sorter (sort_now sorts the whole array in one clock).
    mem_t          mem;
    logic [DW-1:0] rdata_q;
    logic          sort_now;

    function automatic mem_t sort_mem(input mem_t a);
        mem_t          r;
        logic [DW-1:0] t;
        r = a;
        for (int i = 0; i < N - 1; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_owner) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_q <= mem[bus.mem_addr];
        end
        if (sort_now) mem <= sort_mem(mem);
    end
    assign bus.mem_rdata = rdata_q;

    // Event logs, sampled on the falling edge.
    int cyc = 0;
    int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
    int rd_addr_q[$], rd_cyc_q[$];
    int start_cyc_q[$], start_owner_q[$];
    int out_data_q[$], out_last_q[$], out_cyc_q[$];
    int stall_word, stall_cnt, stall_exp;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (stall_word >= 0 && bus.m_valid && out_data_q.size() == stall_word && stall_cnt < 5) begin
            bus.m_ready = 1'b0;
            stall_cnt++;
            check_eq("stall_m_data", bus.m_data, stall_exp);
            check_eq("stall_mem_en", bus.mem_en, 0);
        end else begin
            bus.m_ready = 1'b1;
        end
        if (!rst) begin
            if (bus.mem_en && bus.mem_we) begin
                wr_addr_q.push_back(bus.mem_addr); wr_data_q.push_back(bus.mem_wdata); wr_cyc_q.push_back(cyc);
            end
            if (bus.mem_en && !bus.mem_we) begin
                rd_addr_q.push_back(bus.mem_addr); rd_cyc_q.push_back(cyc);
            end
            if (bus.sort_start) begin
                start_cyc_q.push_back(cyc); start_owner_q.push_back(bus.mem_owner);
            end
            if (bus.m_valid && bus.m_ready) begin
                out_data_q.push_back(bus.m_data); out_last_q.push_back(bus.m_last); out_cyc_q.push_back(cyc);
            end
        end
    end

    logic [DW-1:0] words   [4];
    logic [DW-1:0] exp_out [4];
    int  done_cyc;
    bit  ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        start_cyc_q.delete(); start_owner_q.delete();
        out_data_q.delete(); out_last_q.delete(); out_cyc_q.delete();
    endtask

    task automatic check_reset_outs();
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_m_last", bus.m_last, 0);
        check_eq("rst_sort_start", bus.sort_start, 0);
        check_eq("rst_mem_owner", bus.mem_owner, 0);
        check_eq("rst_mem_en", bus.mem_en, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_m_data", bus.m_data, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
    endtask

    task automatic load_words(input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps && k > 0) begin
                bus.s_valid = 1'b0;
                tick();
            end
            bus.s_valid = 1'b1;
            bus.s_data  = words[k];
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_cyc_q.size() != 0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_eq("start_timeout", 0, 1);
    endtask

    task automatic check_load(input int spacing);
        check_eq("wr_count", wr_addr_q.size(), 4);
        for (int k = 0; k < wr_addr_q.size() && k < 4; k++) begin
            check_eq("wr_addr", wr_addr_q[k], k);
            check_eq("wr_data", wr_data_q[k], words[k]);
            check_eq("wr_cyc", wr_cyc_q[k] - wr_cyc_q[0], k * spacing);
        end
        check_eq("start_count", start_cyc_q.size(), 1);
        if (start_cyc_q.size() != 0 && wr_cyc_q.size() == 4) begin
            check_eq("start_after_last_wr", start_cyc_q[0] - wr_cyc_q[3], 1);
            check_eq("start_mem_owner", start_owner_q[0], 0);
        end
    endtask

    task automatic run_sort();
        repeat (8) tick();
        sort_now = 1'b1;
        tick();
        sort_now      = 1'b0;
        bus.sort_done = 1'b1;
        done_cyc      = cyc + 1;
    endtask

    task automatic wait_outputs();
        for (int i = 0; i < 300 && out_data_q.size() < 4; i++) tick();
        if (out_data_q.size() < 4) check_eq("out_timeout", out_data_q.size(), 4);
    endtask

    task automatic check_readout(input int gap1, input int first_cyc);
        check_eq("out_count", out_data_q.size(), 4);
        check_eq("rd_count", rd_addr_q.size(), 4);
        for (int k = 0; k < rd_addr_q.size() && k < 4; k++) check_eq("rd_addr", rd_addr_q[k], k);
        for (int k = 0; k < out_data_q.size() && k < 4; k++) begin
            check_eq("out_data", out_data_q[k], exp_out[k]);
            check_eq("out_last", out_last_q[k], (k == 3) ? 1 : 0);
            if (k > 0) check_eq("out_spacing", out_cyc_q[k] - out_cyc_q[k-1], (k == 1) ? gap1 : 3);
        end
        if (out_cyc_q.size() != 0) check_eq("first_out_cyc", out_cyc_q[0], first_cyc);
    endtask

    task automatic finish_job();
        repeat (3) tick();
        check_eq("end_start_count", start_cyc_q.size(), 1);
        check_eq("end_s_ready", bus.s_ready, 1);
        check_eq("end_busy", bus.busy, 0);
        bus.sort_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.sort_done = 1'b0;
        sort_now = 1'b0; stall_word = -1; stall_cnt = 0; stall_exp = 0;
        repeat (3) tick();
        check_reset_outs();
        rst = 1'b0;
        #1;
        check_eq("post_rst_s_ready", bus.s_ready, 1);
        check_eq("post_rst_busy", bus.busy, 0);

        // Plain job: reverse-ordered input, full-rate load and read-out.
        words = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
        exp_out = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        clear_logs(); load_words(1'b0); wait_start(ok); check_load(1);
        run_sort(); wait_outputs(); check_readout(3, done_cyc + 3); finish_job();

        // Output backpressure on word 1 for 5 cycles.
        words = '{16'h0003, 16'h0001, 16'h0004, 16'h0002};
        stall_word = 1; stall_cnt = 0; stall_exp = 16'h0002;
        clear_logs(); load_words(1'b0); wait_start(ok); check_load(1);
        run_sort(); wait_outputs(); check_readout(8, done_cyc + 3); finish_job();
        check_eq("stall_cycles", stall_cnt, 5);
        stall_word = -1;

        // Input gaps: s_valid 1,0,1,0,...
        words = '{16'h0002, 16'h0004, 16'h0001, 16'h0003};
        clear_logs(); load_words(1'b1); wait_start(ok); check_load(2);
        run_sort(); wait_outputs(); check_readout(3, done_cyc + 3); finish_job();

        // Reset while waiting for the sorter, then a fresh job.
        words = '{16'h0009, 16'h0008, 16'h0007, 16'h0006};
        clear_logs(); load_words(1'b0); wait_start(ok); check_load(1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check_reset_outs();
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_s_ready", bus.s_ready, 1);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_no_reads", rd_addr_q.size(), 0);
        words = '{16'h0040, 16'h0010, 16'h0030, 16'h0020};
        exp_out = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        clear_logs(); load_words(1'b0); wait_start(ok); check_load(1);
        run_sort(); wait_outputs(); check_readout(3, done_cyc + 3); finish_job();

        // sort_done held high across the whole job: ignored in LOAD and START.
        bus.sort_done = 1'b1;
        words = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
        exp_out = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
        clear_logs(); load_words(1'b0); wait_start(ok); check_load(1);
        wait_outputs();
        if (start_cyc_q.size() != 0) begin
            check_readout(3, start_cyc_q[0] + 4);
            if (rd_cyc_q.size() != 0) check_eq("level_first_rd", rd_cyc_q[0], start_cyc_q[0] + 2);
        end
        repeat (6) tick();
        check_eq("level_start_count", start_cyc_q.size(), 1);
        check_eq("level_rd_count", rd_addr_q.size(), 4);
        check_eq("level_s_ready", bus.s_ready, 1);
        bus.sort_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
